// File: rtl/boot_seq_ctrl.sv
// -----------------------------------------------------------------------------
// boot_seq_ctrl
//   Brings the PLL up from the boot clock and switches the clock mux. The
//   sequence is: wait for the boot oscillator to settle, enable the PLL, wait
//   for lock (with a bounded number of retries), require lock to hold for a
//   guard window, then select the PLL clock. If lock is lost while running,
//   the mux falls back to the boot clock, a sticky LOST flag is raised, and
//   the block waits for lock again with the PLL still enabled.
//
// Ports
//   CLK       in   boot clock, the only clock
//   RST_N     in   asynchronous active-low reset
//   START     in   level request to bring up the PLL clock (CLK domain)
//   PLL_LOCK  in   PLL lock indicator, asynchronous, synchronized internally
//   PLL_EN    out  PLL enable
//   CLK_SEL   out  0 = boot clock, 1 = PLL clock
//   READY     out  PLL clock selected and stable (STATE == RUN)
//   FAIL      out  lock retries exhausted
//   LOST      out  sticky: lock dropped while in RUN
//   STATE     out  current state encoding
// -----------------------------------------------------------------------------
module boot_seq_ctrl #(
  parameter int OSC_SETTLE   = 16,    // 1..65535
  parameter int LOCK_TIMEOUT = 1024,  // 2..65535
  parameter int MAX_RETRY    = 3,     // 0..15
  parameter int SEL_GUARD    = 4      // 1..255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       PLL_LOCK,
  output logic       PLL_EN,
  output logic       CLK_SEL,
  output logic       READY,
  output logic       FAIL,
  output logic       LOST,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_LOCK_WAIT = 3'd2,
    S_GUARD     = 3'd3,
    S_RUN       = 3'd4,
    S_RETRY     = 3'd5,
    S_FAIL      = 3'd6
  } state_e;

  // The counter is cleared on entry to each timed state, so a phase that
  // lasts N cycles ends on the cycle where the counter reads N-1.
  localparam logic [15:0] SETTLE_LAST  = 16'(OSC_SETTLE - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] GUARD_LAST   = 16'(SEL_GUARD - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  retry_q, retry_d;
  logic [1:0]  sync_q;        // sync_q[0] samples PLL_LOCK, sync_q[1] is lock_s
  logic        start_prev_q;  // START one cycle ago, for rising-edge detect
  logic        pll_en_q, pll_en_d;
  logic        clk_sel_q, clk_sel_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        lost_q, lost_d;
  logic        lock_s;
  logic        start_rise;

  assign lock_s     = sync_q[1];
  assign start_rise = START & ~start_prev_q;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (start_rise) lost_d = 1'b0;

    // START low beats every other transition, including a timeout or a lock
    // event in the same cycle.
    if (!START) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          retry_d = '0;
        end
        // SETTLE and RETRY are the same timed wait with PLL_EN low; they
        // differ only in how they were entered.
        S_SETTLE, S_RETRY: begin
          if (cnt_q >= SETTLE_LAST) begin
            state_d = S_LOCK_WAIT;
            cnt_d   = '0;
          end
        end
        S_LOCK_WAIT: begin
          if (lock_s) begin
            state_d = S_GUARD;
            cnt_d   = '0;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_LIMIT) begin
              state_d = S_RETRY;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        // Entered with lock_s already high; every GUARD cycle must also see
        // it high, otherwise restart the lock wait without charging a retry.
        S_GUARD: begin
          if (!lock_s) begin
            state_d = S_LOCK_WAIT;
            cnt_d   = '0;
          end else if (cnt_q >= GUARD_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = S_LOCK_WAIT;
            retry_d = '0;
            lost_d  = 1'b1;
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          // Unused encoding 7 recovers to IDLE.
          state_d = S_IDLE;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end

    // Outputs are functions of the next state so they change on the same
    // edge as STATE. CLK_SEL implies PLL_EN because RUN is in the enable set.
    pll_en_d  = (state_d == S_LOCK_WAIT) || (state_d == S_GUARD) ||
                (state_d == S_RUN);
    clk_sel_d = (state_d == S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      sync_q       <= '0;
      start_prev_q <= 1'b0;
      pll_en_q     <= 1'b0;
      clk_sel_q    <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      sync_q       <= {sync_q[0], PLL_LOCK};
      start_prev_q <= START;
      pll_en_q     <= pll_en_d;
      clk_sel_q    <= clk_sel_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
      lost_q       <= lost_d;
    end
  end

  assign PLL_EN  = pll_en_q;
  assign CLK_SEL = clk_sel_q;
  assign READY   = ready_q;
  assign FAIL    = fail_q;
  assign LOST    = lost_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Bench for boot_seq_ctrl: directed bring-up / timeout / glitch / loss / reset
// sequences with literal expectations, then randomized START / PLL_LOCK /
// reset stimulus, all compared every cycle against a phase-deadline model.
module tb_boot_seq_ctrl;
  localparam int OS = 4, LT = 8, MR = 1, SG = 2;

  logic       CLK = 1'b0, RST_N = 1'b1, START = 1'b0, PLL_LOCK = 1'b0;
  logic       PLL_EN, CLK_SEL, READY, FAIL, LOST;
  logic [2:0] STATE;

  int errors = 0, checks = 0;
  bit cmp_en = 1'b0;

  boot_seq_ctrl #(.OSC_SETTLE(OS), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR), .SEL_GUARD(SG)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .PLL_LOCK(PLL_LOCK),
    .PLL_EN(PLL_EN), .CLK_SEL(CLK_SEL), .READY(READY), .FAIL(FAIL),
    .LOST(LOST), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number (STATE encoding), the edge index the phase began on,
  // and deadlines measured as edges elapsed since entry. lock_s is PLL_LOCK as
  // sampled two edges earlier.
  int m_st = 0, m_enter = 0, m_cyc = 0, m_retries = 0;
  bit m_lost = 0, m_prev_start = 0;
  bit m_hist[2] = '{1'b0, 1'b0};

  task automatic go(input int s);
    m_st = s;
    m_enter = m_cyc;
  endtask

  task automatic model_reset();
    m_st = 0; m_enter = m_cyc; m_retries = 0;
    m_lost = 0; m_prev_start = 0; m_hist = '{1'b0, 1'b0};
  endtask

  task automatic model_edge();
    bit l;
    int k;
    m_cyc++;
    l = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = PLL_LOCK;
    if (START && !m_prev_start) m_lost = 0;
    m_prev_start = START;
    k = m_cyc - m_enter;
    if (!START) begin
      go(0); m_retries = 0;
    end else begin
      case (m_st)
        0: begin go(1); m_retries = 0; end
        1, 5: if (k == OS) go(2);
        2: if (l) go(3);
           else if (k == LT) begin
             if (m_retries < MR) begin m_retries++; go(5); end
             else go(6);
           end
        3: if (!l) go(2); else if (k == SG) go(4);
        4: if (!l) begin m_lost = 1; m_retries = 0; go(2); end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) model_reset();
    else model_edge();
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge CLK);
    if (cmp_en) begin
      check("state",   STATE,   m_st);
      check("pll_en",  PLL_EN,  (m_st == 2 || m_st == 3 || m_st == 4));
      check("clk_sel", CLK_SEL, (m_st == 4));
      check("ready",   READY,   (m_st == 4));
      check("fail_o",  FAIL,    (m_st == 6));
      check("lost",    LOST,    m_lost);
      check("sel_without_en", CLK_SEL & ~PLL_EN, 1'b0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int tog;
    // Async reset before any clock edge.
    #2 RST_N = 1'b0;
    #1;
    check("rst_state", STATE, 0);   check("rst_pll_en", PLL_EN, 0);
    check("rst_clk_sel", CLK_SEL, 0); check("rst_ready", READY, 0);
    check("rst_fail", FAIL, 0);     check("rst_lost", LOST, 0);
    cyc(2);
    RST_N = 1'b1; cmp_en = 1'b1;

    // Nominal bring-up with lock held high.
    cyc(1); START = 1; PLL_LOCK = 1;
    cyc(4); check("nom_settle_state", STATE, 1); check("nom_settle_en", PLL_EN, 0);
    cyc(1); check("nom_lw_state", STATE, 2);     check("nom_lw_en", PLL_EN, 1);
    cyc(1); check("nom_guard_state", STATE, 3);  check("nom_guard_sel", CLK_SEL, 0);
    cyc(2); check("nom_run_state", STATE, 4);    check("nom_run_sel", CLK_SEL, 1);
    check("nom_run_ready", READY, 1);

    // Loss of lock in RUN, then relock.
    PLL_LOCK = 0;
    cyc(2); check("loss_sync_delay", STATE, 4);
    cyc(1); check("loss_state", STATE, 2); check("loss_sel", CLK_SEL, 0);
    check("loss_ready", READY, 0); check("loss_lost", LOST, 1); check("loss_en", PLL_EN, 1);
    PLL_LOCK = 1;
    cyc(4); check("relock_guard", STATE, 3);
    cyc(1); check("relock_run", STATE, 4); check("relock_lost", LOST, 1);

    // START low keeps LOST; START rising clears it.
    START = 0;
    cyc(1); check("stop_state", STATE, 0); check("stop_en", PLL_EN, 0); check("stop_lost", LOST, 1);
    START = 1; PLL_LOCK = 0;
    cyc(1); check("restart_state", STATE, 1); check("restart_lost", LOST, 0);

    // Timeout, one retry, then FAIL.
    cyc(4); check("to_lw1", STATE, 2);
    cyc(7); check("to_lw1_end", STATE, 2);
    cyc(1); check("to_retry", STATE, 5); check("to_retry_en", PLL_EN, 0);
    cyc(4); check("to_lw2", STATE, 2);   check("to_lw2_en", PLL_EN, 1);
    cyc(7); check("to_lw2_end", STATE, 2);
    cyc(1); check("to_fail", STATE, 6);  check("to_fail_o", FAIL, 1); check("to_fail_en", PLL_EN, 0);
    cyc(5); check("fail_hold", STATE, 6);

    // START dropped in the same cycle as a timeout.
    START = 0;
    cyc(1); check("fail_exit", STATE, 0); check("fail_exit_o", FAIL, 0);
    START = 1;
    cyc(12); check("race_pre", STATE, 2);
    START = 0;
    cyc(1); check("race_idle", STATE, 0); check("race_en", PLL_EN, 0);
    cyc(1);

    // Single-cycle lock glitch aborts GUARD; retry count unchanged and the
    // timeout restarts from the abort.
    START = 1;
    cyc(5); check("gl_lw", STATE, 2);
    PLL_LOCK = 1; cyc(1); PLL_LOCK = 0;
    cyc(2); check("gl_guard", STATE, 3);
    cyc(1); check("gl_abort", STATE, 2); check("gl_sel", CLK_SEL, 0);
    cyc(4); check("gl_timer_restart", STATE, 2);
    cyc(4); check("gl_retry_not_fail", STATE, 5);

    // Async reset while in RUN with LOST set.
    START = 0; cyc(1); START = 1; PLL_LOCK = 1;
    cyc(8); check("r_run", STATE, 4);
    PLL_LOCK = 0; cyc(3); check("r_lost", LOST, 1);
    PLL_LOCK = 1; cyc(5); check("r_run2", STATE, 4);
    #2 RST_N = 0;
    #1;
    check("ar_sel", CLK_SEL, 0); check("ar_ready", READY, 0); check("ar_lost", LOST, 0);
    check("ar_state", STATE, 0); check("ar_en", PLL_EN, 0);
    @(negedge CLK); RST_N = 1;

    // Randomized segments with varying lock toggle rates.
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 2))
        0: tog = 3;
        1: tog = 25;
        default: tog = 400;
      endcase
      for (int c = 0; c < 100; c++) begin
        @(negedge CLK);
        if ($urandom_range(0, tog - 1) == 0) PLL_LOCK = ~PLL_LOCK;
        START = ($urandom_range(0, 59) != 0);
        if ($urandom_range(0, 399) == 0) begin
          #2 RST_N = 0;
          @(negedge CLK); RST_N = 1;
        end
      end
    end

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
